alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Execution-side consumer of the 4-bit ALU operation code produced by the ALU control decoder.
- Latches operands on a start/done handshake.
- Executes single-cycle ops (add, sub, move, swap, and/or, compare, nop) in one cycle.
- Executes mult/div iteratively over WIDTH cycles, so the datapath controller must wait on done.

Parameters:
WIDTH, 16, operand/result width in bits (even, >=4)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when busy=0
operation  in  4  op code: 0000 nop, 0001 add, 0010 sub, 0011 mult, 0100 div, 0101 move, 0110 swap, 0111 logic, 1001 compare
logic_sel  in  1  for 0111: 0=AND, 1=OR
a  in  WIDTH  operand A
b  in  WIDTH  operand B
busy  out  1  high while a mult/div iteration is running
done  out  1  one-cycle completion pulse
result  out  WIDTH  primary result
result_hi  out  WIDTH  mult high word / div remainder / swap second word
carry  out  1  add carry-out, sub borrow (a<b unsigned)
zero  out  1  result==0 (compare: a==b)
lt  out  1  compare only: signed a<b
div0  out  1  division by zero occurred
illegal  out  1  unsupported op code

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, carry, zero, lt, div0, illegal = 0; result, result_hi = 0; iteration counter = 0.
- Acceptance: start=1 while state=IDLE at a rising edge. a, b, operation, logic_sel are sampled at that edge only.
- start while busy=1 is ignored (not queued).
- A start coinciding with a done pulse IS accepted (back-to-back).
- Outputs other than done/busy hold their last value until the next completion.
- All flags are recomputed on every completion; flags not defined for an op are 0.
- Single-cycle ops (0000, 0001, 0010, 0101, 0110, 0111, 1001, illegal): result registered at the accepting edge; done=1 for the following cycle; state stays IDLE.
- Mult/div latency: done pulses exactly WIDTH cycles after the accepting edge.
- Per-op results:
  - add: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the sum.
  - sub: result = (a-b) mod 2^WIDTH; carry = borrow.
  - move: result = b; result_hi = 0.
  - swap: result = b; result_hi = a.
  - logic: result = a&b or a|b per logic_sel.
  - compare: result = 0; zero = (a==b); lt = signed a<b.
  - nop: result = 0, result_hi = 0; done still pulses.
  - illegal (1000, 1010..1111): result = 0, result_hi = 0, illegal=1; done pulses.
- Mult (0011), unsigned shift-add:
  - Accepting edge: state -> MUL, counter = 0.
  - One partial-product step per cycle.
  - At the edge where counter==WIDTH-1: write the 2*WIDTH product as {result_hi, result}, done<=1, state -> IDLE.
- Div (0100), unsigned restoring:
  - Same timing as mult; quotient -> result, remainder -> result_hi.
  - b==0: no iteration; single-cycle completion with result = all ones, result_hi = a, div0=1.
- busy = (state != IDLE); it is 0 in the done cycle.
- zero is computed from result for all ops except compare.
- Reset asserted mid-iteration: immediate abort to IDLE, no done pulse; partial state discarded.
- Operand/operation input changes during busy have no effect.

Decomposition:
- Shared package alu_pkg:
  - op-code localparams (OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOV, OP_SWP, OP_LOGIC, OP_CMP); the ALU control decoder and this unit both import them.
  - State encoding IDLE/MUL/DIV.
- One natural sub-module: alu_muldiv_iter.
  - Holds the shared shift register, accumulator and counter; runs both the mult and div sequences.
  - Interface: go, is_div, a, b in; fin, lo, hi out.
  - The top level handles decode, single-cycle ops, flags and the handshake.

Test Plan:
- Reset then add (WIDTH=16): a=0xFFFF, b=0x0001, op=0001 -> next cycle done=1, result=0x0000, carry=1, zero=1, busy never high.
- Sub/compare: a=0x0003, b=0x0005, op=0010 -> result=0xFFFE, carry=1. Then op=1001, a=0xFFFF(-1), b=0x0001 -> lt=1, zero=0, result=0.
- Mult: a=0x1234, b=0x0100 -> busy for 16 cycles, done exactly 16 cycles after accept, {result_hi,result}=0x0012_3400. A second start during busy is ignored (no extra done).
- Div: a=100, b=7 -> result=14, result_hi=2 after 16 cycles. b=0 -> done after 1 cycle, result=0xFFFF, result_hi=100, div0=1.
- Swap/logic/illegal back-to-back starts: swap a=0xAAAA, b=0x5555 -> result=0x5555, result_hi=0xAAAA; next cycle op=0111, logic_sel=1, a=0x00F0, b=0x0F00 -> result=0x0FF0; then op=1010 -> illegal=1, result=0. One done per request.
- Reset mid-mult: assert rst_n=0 at iteration 8 -> all outputs 0 immediately, no done; a fresh add completes normally after release.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes and execution-unit state encoding
package alu_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_MUL   = 4'b0011;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_MOV   = 4'b0101;
  localparam logic [3:0] OP_SWP   = 4'b0110;
  localparam logic [3:0] OP_LOGIC = 4'b0111;
  localparam logic [3:0] OP_CMP   = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  // Ops that run on the shared multi-cycle shift/accumulate datapath.
  function automatic logic op_is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - shared iterative shift-add multiplier / restoring divider
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // acc_q is the product high word (mult) or partial remainder (div);
  // sr_q shifts out multiplier bits (mult) or dividend bits / shifts in quotient bits (div).
  logic             run_q,  run_d;
  logic             div_q,  div_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic [WIDTH-1:0] acc_q,  acc_d;
  logic [WIDTH-1:0] sr_q,   sr_d;
  logic [WIDTH-1:0] opb_q,  opb_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] sr_step;

  assign fin = run_q && (cnt_q == LAST);
  // On the final step the top samples the post-step values directly.
  assign lo  = sr_step;
  assign hi  = acc_step;

  // One mult or div step computed from the current register contents.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (sr_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_trial = {acc_q, sr_q[WIDTH-1]} - {1'b0, opb_q};
    acc_step  = acc_q;
    sr_step   = sr_q;
    if (div_q) begin
      if (!div_trial[WIDTH]) begin
        acc_step = div_trial[WIDTH-1:0];
        sr_step  = {sr_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {acc_q[WIDTH-2:0], sr_q[WIDTH-1]};
        sr_step  = {sr_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = mul_sum[WIDTH:1];
      sr_step  = {mul_sum[0], sr_q[WIDTH-1:1]};
    end
  end

  // Load on go, step while running, stop after the last step.
  always_comb begin
    run_d = run_q;
    div_d = div_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    sr_d  = sr_q;
    opb_d = opb_q;
    if (go) begin
      run_d = 1'b1;
      div_d = is_div;
      cnt_d = '0;
      acc_d = '0;
      sr_d  = a;
      opb_d = b;
    end else if (run_q) begin
      acc_d = acc_step;
      sr_d  = sr_step;
      if (fin) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Iteration registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      sr_q  <= '0;
      opb_q <= '0;
    end else begin
      run_q <= run_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      sr_q  <= sr_d;
      opb_q <= opb_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - ALU execution unit: handshake, single-cycle ops, flags, mult/div sequencing
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic             logic_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             lt,
  output logic             div0,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             lt_q, lt_d;
  logic             div0_q, div0_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_carry, sc_zero, sc_lt, sc_div0, sc_illegal, sc_cmp, sc_iter;
  logic             accept, go, is_div, it_fin;
  logic [WIDTH-1:0] it_lo, it_hi;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
  assign accept = start && (state_q == IDLE);
  assign is_div = (operation == OP_DIV);
  assign go     = accept && sc_iter;

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign result    = res_q;
  assign result_hi = hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign lt        = lt_q;
  assign div0      = div0_q;
  assign illegal   = illegal_q;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .is_div (is_div),
    .a      (a),
    .b      (b),
    .fin    (it_fin),
    .lo     (it_lo),
    .hi     (it_hi)
  );

  // Decode the single-cycle outcome of the presented op; divide by zero resolves here too.
  always_comb begin
    sc_res     = '0;
    sc_hi      = '0;
    sc_carry   = 1'b0;
    sc_lt      = 1'b0;
    sc_div0    = 1'b0;
    sc_illegal = 1'b0;
    sc_cmp     = 1'b0;
    sc_iter    = 1'b0;
    case (operation)
      OP_NOP: ;
      OP_ADD: begin
        sc_res   = sum_w[WIDTH-1:0];
        sc_carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        sc_res   = diff_w[WIDTH-1:0];
        sc_carry = diff_w[WIDTH];
      end
      OP_MUL: sc_iter = 1'b1;
      OP_DIV: begin
        if (b == '0) begin
          sc_res  = '1;
          sc_hi   = a;
          sc_div0 = 1'b1;
        end else begin
          sc_iter = 1'b1;
        end
      end
      OP_MOV: sc_res = b;
      OP_SWP: begin
        sc_res = b;
        sc_hi  = a;
      end
      OP_LOGIC: sc_res = logic_sel ? (a | b) : (a & b);
      OP_CMP: begin
        sc_cmp = 1'b1;
        sc_lt  = ($signed(a) < $signed(b));
      end
      default: sc_illegal = 1'b1;
    endcase
    sc_zero = sc_cmp ? (a == b) : (sc_res == '0);
  end

  // Handshake FSM: complete single-cycle ops immediately, otherwise wait for the iterator.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    res_d     = res_q;
    hi_d      = hi_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    lt_d      = lt_q;
    div0_d    = div0_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (sc_iter) begin
            state_d = is_div ? DIV : MUL;
          end else begin
            done_d    = 1'b1;
            res_d     = sc_res;
            hi_d      = sc_hi;
            carry_d   = sc_carry;
            zero_d    = sc_zero;
            lt_d      = sc_lt;
            div0_d    = sc_div0;
            illegal_d = sc_illegal;
          end
        end
      end
      MUL, DIV: begin
        if (it_fin) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          res_d     = it_lo;
          hi_d      = it_hi;
          carry_d   = 1'b0;
          zero_d    = (it_lo == '0);
          lt_d      = 1'b0;
          div0_d    = 1'b0;
          illegal_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any iteration without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      res_q     <= '0;
      hi_q      <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      lt_q      <= 1'b0;
      div0_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      res_q     <= res_d;
      hi_q      <= hi_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      lt_q      <= lt_d;
      div0_q    <= div0_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
